// File: rtl/cdt_timer_bank_if.sv
// Control/status bundle for cdt_timer_bank: per-channel strobes in, per-channel counts and flags out.
// master = phase sequencer side, slave = timer bank.
interface cdt_timer_bank_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic [CHANNELS-1:0]       load;
  logic [WIDTH-1:0]          load_val;
  logic [CHANNELS-1:0]       clear;
  logic [CHANNELS-1:0]       pause;
  logic [CHANNELS-1:0]       minus;
  logic [CHANNELS*WIDTH-1:0] secs;
  logic [CHANNELS-1:0]       zero;
  logic [CHANNELS-1:0]       expired;
  logic                      tick;

  modport master (
    output load, load_val, clear, pause, minus,
    input  secs, zero, expired, tick
  );

  modport slave (
    input  load, load_val, clear, pause, minus,
    output secs, zero, expired, tick
  );
endinterface

// File: rtl/cdt_timer_bank.sv
// Countdown timer bank: one shared prescaler producing a periodic tick, plus independent
// loadable down-counters with pause, clear, edge-detected minus and optional auto-reload.
module cdt_timer_bank #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cdt_timer_bank_if.slave      bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, EXP} state_t;

  logic [PW-1:0]             presc_reg;
  logic                      tick_w;
  logic [CHANNELS*WIDTH-1:0] secs_all;
  logic [CHANNELS-1:0]       zero_all;
  logic [CHANNELS-1:0]       exp_all;

  // Free-running; tick is decoded from the registered count, so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (presc_reg == PW'(DIV - 1)) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  assign tick_w = (presc_reg == PW'(DIV - 1));

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t           state_reg;
      logic [WIDTH-1:0] secs_reg;
      logic [WIDTH-1:0] reload_reg;
      logic             minus_q_reg;
      logic             minus_evt;
      logic [1:0]       dec;

      assign minus_evt = bus.minus[gi] & ~minus_q_reg;
      // pause only gates the tick; a minus press still shortens a paused channel
      assign dec = {1'b0, tick_w & ~bus.pause[gi]} + {1'b0, minus_evt};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg   <= IDLE;
          secs_reg    <= '0;
          reload_reg  <= '0;
          minus_q_reg <= 1'b0;
        end else begin
          minus_q_reg <= bus.minus[gi];
          if (bus.clear[gi]) begin
            state_reg <= IDLE;
            secs_reg  <= '0;
          end else if (bus.load[gi]) begin
            reload_reg <= bus.load_val;
            secs_reg   <= bus.load_val;
            state_reg  <= (bus.load_val != '0) ? RUN : IDLE;
          end else begin
            case (state_reg)
              RUN: begin
                // secs is never 0 in RUN, so dec >= secs implies a real decrement to 0
                if (WIDTH'(dec) >= secs_reg) begin
                  secs_reg  <= '0;
                  state_reg <= EXP;
                end else begin
                  secs_reg <= secs_reg - WIDTH'(dec);
                end
              end
              EXP: begin
                if (AUTO_RELOAD && (reload_reg != '0)) begin
                  secs_reg  <= reload_reg;
                  state_reg <= RUN;
                end else begin
                  state_reg <= IDLE;
                end
              end
              default: state_reg <= IDLE;
            endcase
          end
        end
      end

      assign secs_all[gi*WIDTH +: WIDTH] = secs_reg;
      assign zero_all[gi]                = (secs_reg == '0);
      assign exp_all[gi]                 = (state_reg == EXP);
    end
  endgenerate

  assign bus.secs    = secs_all;
  assign bus.zero    = zero_all;
  assign bus.expired = exp_all;
  assign bus.tick    = tick_w;
endmodule

// File: tb/tb_cdt_timer_bank.sv
// Directed bench for cdt_timer_bank: DIV=10, one instance without and one with auto-reload.
module tb_cdt_timer_bank;
  localparam int CH = 2;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cdt_timer_bank_if #(.CHANNELS(CH), .WIDTH(W)) if0 ();
  cdt_timer_bank_if #(.CHANNELS(CH), .WIDTH(W)) if1 ();

  cdt_timer_bank #(.CLK_HZ(10), .TICK_HZ(1), .CHANNELS(CH), .WIDTH(W), .AUTO_RELOAD(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  cdt_timer_bank #(.CLK_HZ(10), .TICK_HZ(1), .CHANNELS(CH), .WIDTH(W), .AUTO_RELOAD(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // advance until tick is visible, so the next edge samples it
  task automatic wait_tick();
    int n = 0;
    while (!if0.tick && n < 20) begin
      step(1);
      n++;
    end
    check("tick_seen", 32'(if0.tick), 32'd1);
  endtask

  task automatic load0(input int ch, input logic [W-1:0] v);
    if0.load_val = v;
    if0.load[ch] = 1'b1;
    step(1);
    if0.load[ch] = 1'b0;
  endtask

  task automatic load1(input int ch, input logic [W-1:0] v);
    if1.load_val = v;
    if1.load[ch] = 1'b1;
    step(1);
    if1.load[ch] = 1'b0;
  endtask

  initial begin
    if0.load = '0; if0.load_val = '0; if0.clear = '0; if0.pause = '0; if0.minus = '0;
    if1.load = '0; if1.load_val = '0; if1.clear = '0; if1.pause = '0; if1.minus = '0;

    // 1: reset values and tick cadence
    step(3);
    check("rst_secs", 32'(if0.secs), 32'd0);
    check("rst_zero", 32'(if0.zero), 32'd3);
    check("rst_expired", 32'(if0.expired), 32'd0);
    check("rst_tick", 32'(if0.tick), 32'd0);
    rst_n = 1'b1;
    step(8);
    check("tick_c8", 32'(if0.tick), 32'd0);
    step(1);
    check("tick_c9", 32'(if0.tick), 32'd1);
    step(1);
    check("tick_c10", 32'(if0.tick), 32'd0);
    step(9);
    check("tick_c19", 32'(if0.tick), 32'd1);

    // 2: ch0 counts 3,2,1,0 and expires once
    load0(0, 8'd3);
    check("t2_load", 32'(if0.secs[7:0]), 32'd3);
    wait_tick(); step(1);
    check("t2_s2", 32'(if0.secs[7:0]), 32'd2);
    wait_tick(); step(1);
    check("t2_s1", 32'(if0.secs[7:0]), 32'd1);
    check("t2_noexp", 32'(if0.expired), 32'd0);
    wait_tick(); step(1);
    check("t2_s0", 32'(if0.secs[7:0]), 32'd0);
    check("t2_exp", 32'(if0.expired), 32'd1);
    check("t2_zero", 32'(if0.zero[0]), 32'd1);
    step(1);
    check("t2_exp_gone", 32'(if0.expired), 32'd0);
    wait_tick(); step(1);
    check("t2_idle", 32'(if0.secs[7:0]), 32'd0);
    check("t2_idle_zero", 32'(if0.zero[0]), 32'd1);

    // 3: pause holds ch1, minus edge still shortens, held minus counts once
    load0(1, 8'd5);
    if0.pause[1] = 1'b1;
    wait_tick(); step(1);
    wait_tick(); step(1);
    check("t3_paused", 32'(if0.secs[15:8]), 32'd5);
    if0.minus[1] = 1'b1; step(1); if0.minus[1] = 1'b0; step(1);
    check("t3_minus", 32'(if0.secs[15:8]), 32'd4);
    if0.minus[1] = 1'b1; step(20); if0.minus[1] = 1'b0; step(1);
    check("t3_held", 32'(if0.secs[15:8]), 32'd3);
    if0.clear[1] = 1'b1; step(1); if0.clear[1] = 1'b0; if0.pause[1] = 1'b0;
    check("t3_clear", 32'(if0.secs[15:8]), 32'd0);
    check("t3_clear_noexp", 32'(if0.expired), 32'd0);

    // 4: minus coincident with tick, saturating at 0 and normal double step
    load0(0, 8'd1);
    wait_tick();
    if0.minus[0] = 1'b1; step(1); if0.minus[0] = 1'b0;
    check("t4_sat", 32'(if0.secs[7:0]), 32'd0);
    check("t4_sat_exp", 32'(if0.expired), 32'd1);
    step(1);
    check("t4_sat_once", 32'(if0.expired), 32'd0);
    load0(0, 8'd4);
    wait_tick();
    if0.minus[0] = 1'b1; step(1); if0.minus[0] = 1'b0;
    check("t4_dbl", 32'(if0.secs[7:0]), 32'd2);
    check("t4_dbl_noexp", 32'(if0.expired), 32'd0);

    // 5: auto-reload instance
    load1(0, 8'd2);
    check("t5_load", 32'(if1.secs[7:0]), 32'd2);
    wait_tick(); step(1);
    check("t5_s1", 32'(if1.secs[7:0]), 32'd1);
    wait_tick(); step(1);
    check("t5_s0", 32'(if1.secs[7:0]), 32'd0);
    check("t5_exp", 32'(if1.expired), 32'd1);
    step(1);
    check("t5_reload", 32'(if1.secs[7:0]), 32'd2);
    check("t5_exp_gone", 32'(if1.expired), 32'd0);
    wait_tick(); step(1);
    wait_tick(); step(1);
    check("t5_s0b", 32'(if1.secs[7:0]), 32'd0);
    check("t5_expb", 32'(if1.expired), 32'd1);
    step(1);
    check("t5_reloadb", 32'(if1.secs[7:0]), 32'd2);
    wait_tick(); step(1);
    check("t5_s1c", 32'(if1.secs[7:0]), 32'd1);
    if1.clear[0] = 1'b1; step(1); if1.clear[0] = 1'b0;
    check("t5_clear", 32'(if1.secs[7:0]), 32'd0);
    check("t5_clear_noexp", 32'(if1.expired), 32'd0);
    step(12);
    check("t5_no_reload", 32'(if1.secs[7:0]), 32'd0);
    load1(0, 8'd3);
    load1(0, 8'd0);
    check("t5_load0", 32'(if1.secs[7:0]), 32'd0);
    check("t5_load0_noexp", 32'(if1.expired), 32'd0);
    check("t5_load0_zero", 32'(if1.zero[0]), 32'd1);
    step(12);
    check("t5_load0_idle", 32'(if1.secs[7:0]), 32'd0);

    // 6: asynchronous reset mid-count
    wait_tick(); step(1);
    load0(0, 8'd7);
    load0(1, 8'd2);
    check("t6_pre_ch0", 32'(if0.secs[7:0]), 32'd7);
    check("t6_pre_ch1", 32'(if0.secs[15:8]), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_secs", 32'(if0.secs), 32'd0);
    check("t6_zero", 32'(if0.zero), 32'd3);
    check("t6_expired", 32'(if0.expired), 32'd0);
    check("t6_tick", 32'(if0.tick), 32'd0);
    check("t6_u1_secs", 32'(if1.secs), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(8);
    check("t6_tick_c8", 32'(if0.tick), 32'd0);
    check("t6_secs_after", 32'(if0.secs), 32'd0);
    step(1);
    check("t6_tick_c9", 32'(if0.tick), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdt_timer_bank.md
Name: cdt_timer_bank

Overview:
Multi-channel countdown timer bank for the traffic-light controller. One shared prescaler divides the system clock down to a seconds tick. Each channel is an independent loadable down-counter with pause, clear and pedestrian "minus" shortening. Each channel reports its remaining seconds, a zero level and a one-cycle expiry pulse, with optional auto-reload, so the phase sequencer can run several phase timers (e.g. vehicle and pedestrian) from one block.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; DIV = CLK_HZ/TICK_HZ, DIV >= 2, integer.
TICK_HZ, 1, tick rate (1 = seconds).
CHANNELS, 2, number of independent countdown channels (>= 1).
WIDTH, 8, bit width of each channel count.
AUTO_RELOAD, 0, 1 = a channel restarts from its last loaded value on expiry; 0 = it stops at zero.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
load  in  CHANNELS  per-channel load strobe; captures load_val.
load_val  in  WIDTH  start value, shared by all channels.
clear  in  CHANNELS  per-channel abort to idle; produces no expiry.
pause  in  CHANNELS  per-channel level; freezes tick decrement.
minus  in  CHANNELS  per-channel shorten request; edge-detected internally.
secs  out  CHANNELS*WIDTH  remaining count; channel i occupies bits [i*WIDTH +: WIDTH].
zero  out  CHANNELS  high while a channel's secs == 0.
expired  out  CHANNELS  one-cycle pulse when a channel reaches 0 by counting.
tick  out  1  high for one clk cycle every DIV cycles.

Behaviour:
- Reset, asynchronous, while rst_n = 0:
  - prescaler = 0, tick = 0, all minus edge-detect registers = 0.
  - Every channel: state IDLE, secs = 0, reload register = 0, zero = 1, expired = 0.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick = (prescaler == DIV-1) and is free-running, unaffected by load, pause or clear.
  - The first tick appears in cycle DIV-1 after reset release.
- minus edge detect: minus_evt[i] = minus[i] & ~minus_q[i]. A held level counts once.
- Per-channel states:
  - IDLE: secs = 0, no counting.
  - RUN: counting.
  - EXP: exactly one cycle; expired = 1 and secs = 0.
- Priority each cycle, highest first:
  - rst_n
  - clear
  - load
  - decrement
- clear[i]:
  - Goes to IDLE, secs = 0.
  - No expired pulse; the reload register is kept.
- load[i]:
  - Sets reload = load_val.
  - If load_val != 0: secs = load_val, state RUN.
  - If load_val == 0: secs = 0, state IDLE, no expired pulse.
  - Allowed from any state. A load during EXP overrides auto-reload.
  - Any tick or minus in the same cycle is ignored.
- Decrement, RUN only:
  - dec = (tick & ~pause[i]) + minus_evt[i], so dec is 0, 1 or 2. pause does not block minus.
  - secs_next = secs - dec, saturating at 0; no wrap-around below 0.
  - If secs_next == 0: secs = 0, enter EXP.
- EXP, next cycle:
  - If AUTO_RELOAD = 1 and reload != 0: secs = reload, state RUN. A tick in that cycle is not applied.
  - Otherwise: state IDLE.
- In IDLE and EXP, tick and minus are ignored, and minus is not queued.
- Outputs:
  - secs, zero and expired are registered (state-derived); there is no combinational input-to-output path.
  - Latency: secs changes on the clk edge that samples the tick, load, clear or minus condition.
  - expired goes high in the cycle after the decrement to 0 is sampled (the first cycle secs reads 0).
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset mid-count discards all state immediately; no expired pulse.

Test Plan:
1. CLK_HZ=10, TICK_HZ=1, CHANNELS=2, WIDTH=8. Release reset → secs=0, zero=2'b11, expired=0; tick high at cycles 9, 19, 29, ...
2. Load ch0 with 3, no pause → secs0 reads 3, 2, 1, 0 on successive ticks. expired[0] is high for exactly one cycle when secs0 first reads 0, then zero[0]=1 and ch0 stays IDLE (AUTO_RELOAD=0).
3. Load ch1 with 5, assert pause[1] over two ticks → secs1 holds 5. Pulse minus[1] during pause → secs1 = 4. Hold minus[1] high for 20 cycles → only one decrement.
4. ch0 secs=1 with minus edge coincident with unpaused tick → secs0 = 0 (saturating, not 255), one expired pulse. Separately, ch0 secs=4 with the same coincident events → secs0 = 2.
5. AUTO_RELOAD=1, load ch0 with 2 → sequence 2, 1, 0 (expired), then 2, 1, 0 repeating. Assert clear[0] mid-count → secs0 = 0, no expired pulse, no reload. Load value 0 → IDLE, no pulse.
6. Drop rst_n asynchronously between clock edges while ch0 secs=7 and ch1 secs=2 → all outputs take reset values immediately. After release, the first tick occurs again at cycle DIV-1.
